// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers DEPTH {pc, instr} pairs between fetch and decode.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [31:0]      r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_rd_en;

    assign count = r_count;

    // Handshake decode, head-entry read mux and optional bypass selection.
    always_comb begin
        w_empty  = (r_count == CNT_ZERO);
        w_full   = (r_count == CNT_FULL);
        w_bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        w_bypass = w_empty & in_valid & ~flush;
`else
        w_bypass = 1'b0;
`endif
        in_ready  = ~w_full;
        out_valid = ~w_empty | w_bypass;
        if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (!w_empty) begin
            out_pc    = r_pc_mem[r_rd_ptr];
            out_instr = r_instr_mem[r_rd_ptr];
        end else begin
            out_pc    = 32'h0000_0000;
            out_instr = 32'h0000_0000;
        end
        w_push  = in_valid & in_ready;
        w_pop   = out_valid & out_ready;
        // A bypassed pair consumed by decode never touches storage.
        w_wr_en = w_push & ~(w_bypass & out_ready);
        w_rd_en = w_pop & ~w_empty;
    end

    // Pointer and occupancy state; flush outranks any push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else if (flush) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_en && !flush) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default and bypass builds).
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_cmp;
    int n_err;

    fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    initial begin
        logic byp;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = 1'b1;
`else
        byp = 1'b0;
`endif
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'h0; in_instr = 32'h0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        #9 reset = 1'b1;

        // Mid-stream asynchronous reset with three entries held.
        for (int k = 0; k < 3; k++) begin
            offer(32'h0000_1000 + 32'(4 * k));
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_count", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_pc", out_pc, 32'h0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        offer(32'h0000_3000);
        #1;
        chk("empty_offer_out_valid", 32'(out_valid), byp ? 32'd1 : 32'd0);
        tick();
        in_valid = 1'b0;
        chk("post_rst_out_pc", out_pc, 32'h0000_3000);
        chk("post_rst_out_instr", out_instr, instr_of(32'h0000_3000));
        chk("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain1_count", 32'(count), 32'd0);

        // Fill to full, reject a fifth push, then drain in order.
        for (int k = 0; k < 4; k++) begin
            offer(32'h0000_3000 + 32'(4 * k));
            tick();
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        offer(32'h0000_3010);
        tick();
        in_valid = 1'b0;
        chk("reject_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_order", out_pc, 32'h0000_3000 + 32'(4 * k));
            tick();
        end
        out_ready = 1'b0;
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("drained_out_pc", out_pc, 32'h0);

        // Simultaneous push and pop for ten cycles at occupancy two.
        offer(32'h0000_3000); tick();
        offer(32'h0000_3004); tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(32'h0000_3008 + 32'(4 * k));
            #1;
            chk("pp_head", out_pc, 32'h0000_3000 + 32'(4 * k));
            tick();
            chk("pp_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b0;

        // Full with pop and push offered: only the pop happens.
        offer(32'h0000_3030); tick();
        offer(32'h0000_3034); tick();
        chk("fp_count4", 32'(count), 32'd4);
        offer(32'h0000_3038);
        out_ready = 1'b1;
        #1;
        chk("fp_in_ready", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk("fp_count3", 32'(count), 32'd3);
        tick();
        in_valid = 1'b0;
        chk("fp_accept_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        chk("fp_head0", out_pc, 32'h0000_302C); tick();
        chk("fp_head1", out_pc, 32'h0000_3030); tick();
        chk("fp_head2", out_pc, 32'h0000_3034); tick();
        chk("fp_head3", out_pc, 32'h0000_3038); tick();
        out_ready = 1'b0;
        chk("fp_empty", 32'(count), 32'd0);

        // Flush discards stored entries and the same-cycle push.
        for (int k = 0; k < 3; k++) begin
            offer(32'h0000_3000 + 32'(4 * k));
            tick();
        end
        offer(32'h0000_3040);
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_pc", out_pc, 32'h0);
        offer(32'h0000_3100);
        tick();
        in_valid = 1'b0;
        chk("post_flush_pc", out_pc, 32'h0000_3100);
        out_ready = 1'b1;
        tick();
        chk("empty_pop_count", 32'(count), 32'd0);
        tick();
        chk("empty_pop_hold", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush holds out_valid low on an empty queue even with a pair offered.
        offer(32'h0000_3200);
        flush = 1'b1;
        #1;
        chk("flush_blocks_bypass", 32'(out_valid), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;

        // Empty-queue offer with decode ready: bypass vs. one-cycle latency.
        offer(32'h0000_3020);
        out_ready = 1'b1;
        #1;
        chk("byp_out_valid", 32'(out_valid), byp ? 32'd1 : 32'd0);
        chk("byp_out_pc", out_pc, byp ? 32'h0000_3020 : 32'h0);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("byp_next_count", 32'(count), byp ? 32'd0 : 32'd1);
        chk("byp_next_out_valid", 32'(out_valid), byp ? 32'd0 : 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("final_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
